// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue/branch inputs and forwarding/stall outputs of the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              IssueValid;
    logic              IssueWrites;
    logic              IssueIsLoad;
    logic [REG_AW-1:0] IssueRd;
    logic [REG_AW-1:0] IssueRs;
    logic [REG_AW-1:0] IssueRt;
    logic              IssueUsesRs;
    logic              IssueUsesRt;
    logic              BranchTaken;
    logic [SEL_W-1:0]  FwdSelPrimary;
    logic [SEL_W-1:0]  FwdSelSecondary;
    logic              StallReq;
    logic              PurgeFront;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  PurgeCount;

    modport master (
        output IssueValid, IssueWrites, IssueIsLoad, IssueRd, IssueRs, IssueRt,
               IssueUsesRs, IssueUsesRt, BranchTaken,
        input  FwdSelPrimary, FwdSelSecondary, StallReq, PurgeFront, StallCount, PurgeCount
    );

    modport slave (
        input  IssueValid, IssueWrites, IssueIsLoad, IssueRd, IssueRs, IssueRt,
               IssueUsesRs, IssueUsesRt, BranchTaken,
        output FwdSelPrimary, FwdSelSecondary, StallReq, PurgeFront, StallCount, PurgeCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift-register write scoreboard driving forwarding selects, stall and purge
module hazard_scoreboard #(
    parameter int REG_AW           = 4,
    parameter int STAGES           = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int BRANCH_STAGE     = 1,
    parameter int FWD_EN           = 1,
    parameter int ZERO_REG_EN      = 1,
    parameter int CNT_W            = 16,
    parameter int SEL_W            = $clog2(STAGES+1)
) (
    input  logic               ClockPipeline,
    input  logic               Reset,
    hazard_scoreboard_if.slave bus
);
    logic              v_q  [STAGES];
    logic              v_d  [STAGES];
    logic [REG_AW-1:0] rd_q [STAGES];
    logic [REG_AW-1:0] rd_d [STAGES];
    logic              ld_q [STAGES];
    logic              ld_d [STAGES];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  purge_cnt_q, purge_cnt_d;

    logic [REG_AW-1:0] src  [2];
    logic              uses [2];
    logic [SEL_W-1:0]  sel  [2];
    logic              hz   [2];
    logic              stall;
    logic              issue_en;

    always_comb begin : resolve_sources
        logic             match;
        logic             match_ld;
        logic             active;
        logic [SEL_W-1:0] match_k;
        src[0]  = bus.IssueRs;
        src[1]  = bus.IssueRt;
        uses[0] = bus.IssueUsesRs;
        uses[1] = bus.IssueUsesRt;
        for (int s = 0; s < 2; s++) begin
            match    = 1'b0;
            match_ld = 1'b0;
            match_k  = '0;
            // Scan oldest to youngest so the youngest matching writer is the one kept.
            for (int k = STAGES-1; k >= 0; k--) begin
                if (v_q[k] && rd_q[k] == src[s]) begin
                    match    = 1'b1;
                    match_ld = ld_q[k];
                    match_k  = SEL_W'(k);
                end
            end
            active = bus.IssueValid & uses[s] & ~Reset &
                     ~((ZERO_REG_EN != 0) && (src[s] == '0));
            sel[s] = '0;
            hz[s]  = 1'b0;
            if (active && match) begin
                if (FWD_EN != 0) begin
                    if (!match_ld || match_k >= SEL_W'(LOAD_READY_STAGE))
                        sel[s] = match_k + SEL_W'(1);
                    else
                        hz[s] = 1'b1;
                end else if (match_k != SEL_W'(STAGES-1)) begin
                    hz[s] = 1'b1;
                end
            end
        end
    end

    assign stall = bus.IssueValid & ~bus.BranchTaken & ~Reset & (hz[0] | hz[1]);

    assign bus.FwdSelPrimary   = sel[0];
    assign bus.FwdSelSecondary = sel[1];
    assign bus.StallReq        = stall;
    assign bus.PurgeFront      = bus.BranchTaken & ~Reset;
    assign bus.StallCount      = stall_cnt_q;
    assign bus.PurgeCount      = purge_cnt_q;

    always_comb begin
        issue_en = bus.IssueValid & bus.IssueWrites & ~stall & ~bus.BranchTaken &
                   ((ZERO_REG_EN == 0) || (bus.IssueRd != '0));
        v_d[0]  = issue_en;
        rd_d[0] = bus.IssueRd;
        ld_d[0] = bus.IssueIsLoad;
        // Entries younger than the resolving branch are squashed as they shift.
        for (int k = 1; k < STAGES; k++) begin
            v_d[k]  = v_q[k-1] & ~(bus.BranchTaken && ((k-1) < BRANCH_STAGE));
            rd_d[k] = rd_q[k-1];
            ld_d[k] = ld_q[k-1];
        end
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        purge_cnt_d = (bus.BranchTaken && !(&purge_cnt_q)) ? purge_cnt_q + CNT_W'(1) : purge_cnt_q;
    end

    always_ff @(posedge ClockPipeline or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                rd_q[k] <= '0;
                ld_q[k] <= 1'b0;
            end
            stall_cnt_q <= '0;
            purge_cnt_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= v_d[k];
                rd_q[k] <= rd_d[k];
                ld_q[k] <= ld_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            purge_cnt_q <= purge_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - random and directed checks of hazard_scoreboard against a reference model
module tb_hazard_scoreboard;
    localparam int STAGES = 3;
    localparam int LRS    = 1;
    localparam int BRS    = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       i_valid = 0, i_wr = 0, i_ld = 0, i_urs = 0, i_urt = 0, i_br = 0;
    logic [3:0] i_rd = 0, i_rs = 0, i_rt = 0;

    hazard_scoreboard_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) bf ();
    hazard_scoreboard_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) bn ();

    assign bf.IssueValid = i_valid;  assign bn.IssueValid = i_valid;
    assign bf.IssueWrites = i_wr;    assign bn.IssueWrites = i_wr;
    assign bf.IssueIsLoad = i_ld;    assign bn.IssueIsLoad = i_ld;
    assign bf.IssueRd = i_rd;        assign bn.IssueRd = i_rd;
    assign bf.IssueRs = i_rs;        assign bn.IssueRs = i_rs;
    assign bf.IssueRt = i_rt;        assign bn.IssueRt = i_rt;
    assign bf.IssueUsesRs = i_urs;   assign bn.IssueUsesRs = i_urs;
    assign bf.IssueUsesRt = i_urt;   assign bn.IssueUsesRt = i_urt;
    assign bf.BranchTaken = i_br;    assign bn.BranchTaken = i_br;

    hazard_scoreboard dut_f (.ClockPipeline(clk), .Reset(rst), .bus(bf.slave));
    hazard_scoreboard #(.FWD_EN(0)) dut_n (.ClockPipeline(clk), .Reset(rst), .bus(bn.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: per instance (0 = forwarding, 1 = no forwarding), who is writing what in each stage.
    bit m_v  [2][STAGES];
    int m_rd [2][STAGES];
    bit m_l  [2][STAGES];
    int m_sc [2];
    int m_pc [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < STAGES; k++) begin
                m_v[i][k] = 0; m_rd[i][k] = 0; m_l[i][k] = 0;
            end
            m_sc[i] = 0; m_pc[i] = 0;
        end
    endtask

    task automatic model_src(input int i, input int r, input bit use_it, output int sel, output bit hz);
        int  kk;
        bit  found;
        sel = 0; hz = 0; found = 0; kk = 0;
        if (!i_valid || !use_it || r == 0) return;
        for (int k = 0; k < STAGES; k++) begin
            if (!found && m_v[i][k] && m_rd[i][k] == r) begin
                found = 1; kk = k;
            end
        end
        if (!found) return;
        if (i == 0) begin
            if (kk >= (m_l[i][kk] ? LRS : 0)) sel = kk + 1;
            else hz = 1;
        end else begin
            if (kk != STAGES-1) hz = 1;
        end
    endtask

    task automatic drive(input bit v, input bit w, input bit l, input int rd, input int rs,
                         input int rt, input bit urs, input bit urt, input bit br);
        i_valid = v; i_wr = w; i_ld = l; i_rd = 4'(rd); i_rs = 4'(rs); i_rt = 4'(rt);
        i_urs = urs; i_urt = urt; i_br = br;
        #1;
    endtask

    task automatic step();
        int    sp, ss;
        bit    hp, hs;
        bit    st [2];
        string nm;
        for (int i = 0; i < 2; i++) begin
            nm = (i == 0) ? "fwd" : "nofwd";
            model_src(i, int'(i_rs), i_urs, sp, hp);
            model_src(i, int'(i_rt), i_urt, ss, hs);
            st[i] = i_valid && !i_br && (hp || hs);
            chk({nm, "_stall"}, (i == 0) ? bf.StallReq : bn.StallReq, st[i]);
            chk({nm, "_purge"}, (i == 0) ? bf.PurgeFront : bn.PurgeFront, i_br);
            chk({nm, "_scnt"}, (i == 0) ? bf.StallCount : bn.StallCount, m_sc[i]);
            chk({nm, "_pcnt"}, (i == 0) ? bf.PurgeCount : bn.PurgeCount, m_pc[i]);
            if (!hp) chk({nm, "_selp"}, (i == 0) ? bf.FwdSelPrimary : bn.FwdSelPrimary, sp);
            if (!hs) chk({nm, "_sels"}, (i == 0) ? bf.FwdSelSecondary : bn.FwdSelSecondary, ss);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int k = STAGES-1; k >= 1; k--) begin
                m_v[i][k]  = m_v[i][k-1] && !(i_br && (k-1) < BRS);
                m_rd[i][k] = m_rd[i][k-1];
                m_l[i][k]  = m_l[i][k-1];
            end
            m_v[i][0]  = i_valid && i_wr && !st[i] && !i_br && i_rd != 0;
            m_rd[i][0] = int'(i_rd);
            m_l[i][0]  = i_ld;
            if (st[i]) m_sc[i]++;
            if (i_br) m_pc[i]++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_stall", bf.StallReq, 0);
        chk("rst_selp", bf.FwdSelPrimary, 0);
        chk("rst_sels", bf.FwdSelSecondary, 0);
        chk("rst_scnt", bf.StallCount, 0);
        chk("rst_pcnt", bf.PurgeCount, 0);
        chk("rst_nstall", bn.StallReq, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // ALU chain: r3 produced, then read on four consecutive cycles.
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); step();
        for (int j = 1; j <= 4; j++) begin
            drive(1, 0, 0, 0, 3, 0, 1, 0, 0);
            chk("alu_sel", bf.FwdSelPrimary, (j < 4) ? j : 0);
            chk("alu_stall", bf.StallReq, 0);
            step();
        end

        // Load-use: one bubble, then forward from MEM.
        do_reset();
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 5, 0, 1, 0); chk("lu_stall1", bf.StallReq, 1); step();
        drive(1, 0, 0, 0, 0, 5, 0, 1, 0); chk("lu_stall2", bf.StallReq, 0);
        chk("lu_sel", bf.FwdSelSecondary, 2); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk("lu_scnt", bf.StallCount, 1); step();

        // Youngest writer wins; r0 never hazards.
        do_reset();
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0); step();
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 2, 0, 1, 0, 0); chk("young_sel", bf.FwdSelPrimary, 1); step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0); chk("r0_sel", bf.FwdSelPrimary, 0);
        chk("r0_stall", bf.StallReq, 0); step();

        // Branch purge beats a pending load-use stall.
        do_reset();
        drive(1, 1, 1, 6, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 6, 0, 1, 1); chk("br_purge", bf.PurgeFront, 1);
        chk("br_stall", bf.StallReq, 0); step();
        drive(1, 0, 0, 0, 0, 6, 0, 1, 0); chk("br_sel", bf.FwdSelSecondary, 0);
        chk("br_pcnt", bf.PurgeCount, 1); step();

        // No forwarding: back-to-back dependency waits STAGES-1 cycles.
        do_reset();
        drive(1, 1, 0, 7, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 7, 0, 1, 0, 0); chk("nf_stall1", bn.StallReq, 1); step();
        drive(1, 0, 0, 0, 7, 0, 1, 0, 0); chk("nf_stall2", bn.StallReq, 1); step();
        drive(1, 0, 0, 0, 7, 0, 1, 0, 0); chk("nf_stall3", bn.StallReq, 0);
        chk("nf_sel", bn.FwdSelPrimary, 0); chk("nf_scnt", bn.StallCount, 2); step();

        // Asynchronous reset in the middle of a load-use stall.
        do_reset();
        drive(1, 1, 1, 5, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 5, 0, 1, 0); chk("ar_stall_pre", bf.StallReq, 1);
        #2;
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 0, 1, 0); chk("ar_sel", bf.FwdSelSecondary, 0);
        chk("ar_stall_post", bf.StallReq, 0); step();

        // Random traffic over a small register window to provoke frequent matches.
        do_reset();
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
